// File: rtl/reg_wb_scheduler_if.sv
// Issue, writeback and register-file write-port signals of the scheduler, grouped for port use.
interface reg_wb_scheduler_if #(
    parameter int unsigned CNT_W = 4
);
    logic             IssueValid;
    logic [4:0]       IssueRS1;
    logic [4:0]       IssueRS2;
    logic             IssueUseRS1;
    logic             IssueUseRS2;
    logic [4:0]       IssueRD;
    logic             IssueWrEn;
    logic             IssueReady;
    logic             Flush;
    logic             WbAValid;
    logic [4:0]       WbARD;
    logic [31:0]      WbAData;
    logic             WbAReady;
    logic             WbMValid;
    logic [4:0]       WbMRD;
    logic [31:0]      WbMData;
    logic             WbMReady;
    logic             LdR;
    logic [4:0]       RD;
    logic [31:0]      DataR;
    logic [31:0]      Busy;
    logic [CNT_W-1:0] OutCnt;

    modport master (
        output IssueValid, IssueRS1, IssueRS2, IssueUseRS1, IssueUseRS2, IssueRD, IssueWrEn,
        output Flush, WbAValid, WbARD, WbAData, WbMValid, WbMRD, WbMData,
        input  IssueReady, WbAReady, WbMReady, LdR, RD, DataR, Busy, OutCnt
    );

    modport slave (
        input  IssueValid, IssueRS1, IssueRS2, IssueUseRS1, IssueUseRS2, IssueRD, IssueWrEn,
        input  Flush, WbAValid, WbARD, WbAData, WbMValid, WbMRD, WbMData,
        output IssueReady, WbAReady, WbMReady, LdR, RD, DataR, Busy, OutCnt
    );
endinterface

// File: rtl/reg_wb_scheduler.sv
// Issue scoreboard (RAW/WAW/outstanding-limit stall) and round-robin arbiter for the single
// register-file write port shared by the ALU (A) and load unit (M).
module reg_wb_scheduler #(
    parameter int unsigned MAX_OUT = 4,
    parameter int unsigned CNT_W   = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    reg_wb_scheduler_if.slave io_bus
);
    logic [31:0]      r_busy;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ldr;
    logic [4:0]       r_rd;
    logic [31:0]      r_data;
    logic             r_ptr_m;

    logic             w_issue_real;
    logic             w_cnt_full;
    logic             w_issue_ready;
    logic             w_issue_fire;
    logic             w_gnt_a;
    logic             w_gnt_m;
    logic             w_gnt;
    logic [4:0]       w_gnt_rd;
    logic [31:0]      w_gnt_data;
    logic             w_inc;
    logic             w_dec;
    logic [31:0]      w_busy_d;

    always_comb begin
        w_issue_real  = io_bus.IssueWrEn && (io_bus.IssueRD != 5'd0);
        w_cnt_full    = (r_cnt == CNT_W'(MAX_OUT));
        w_issue_ready = !(io_bus.IssueUseRS1 && r_busy[io_bus.IssueRS1]) &&
                        !(io_bus.IssueUseRS2 && r_busy[io_bus.IssueRS2]) &&
                        !(w_issue_real && r_busy[io_bus.IssueRD]) &&
                        !(w_issue_real && w_cnt_full) &&
                        !io_bus.Flush;
        w_issue_fire  = io_bus.IssueValid && w_issue_ready && w_issue_real;

        w_gnt_a    = io_bus.WbAValid && (!io_bus.WbMValid || !r_ptr_m);
        w_gnt_m    = io_bus.WbMValid && (!io_bus.WbAValid || r_ptr_m);
        w_gnt      = w_gnt_a || w_gnt_m;
        w_gnt_rd   = w_gnt_a ? io_bus.WbARD : io_bus.WbMRD;
        w_gnt_data = w_gnt_a ? io_bus.WbAData : io_bus.WbMData;

        // r_ldr is only ever set for rd!=0, so it doubles as the retire strobe for r_rd
        w_inc = w_issue_fire;
        w_dec = r_ldr && (r_cnt != '0);

        w_busy_d = r_busy;
        if (r_ldr) begin
            w_busy_d[r_rd] = 1'b0;
        end
        if (w_issue_fire) begin
            w_busy_d[io_bus.IssueRD] = 1'b1;
        end
        w_busy_d[0] = 1'b0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_busy  <= '0;
            r_cnt   <= '0;
            r_ldr   <= 1'b0;
            r_rd    <= '0;
            r_data  <= '0;
            r_ptr_m <= 1'b0;
        end else begin
            r_busy <= w_busy_d;
            if (w_inc && !w_dec) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else if (w_dec && !w_inc) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            r_ldr <= w_gnt && (w_gnt_rd != 5'd0);
            if (w_gnt) begin
                r_rd    <= w_gnt_rd;
                r_data  <= w_gnt_data;
                r_ptr_m <= w_gnt_a;
            end
        end
    end

    assign io_bus.IssueReady = w_issue_ready;
    assign io_bus.WbAReady   = w_gnt_a;
    assign io_bus.WbMReady   = w_gnt_m;
    assign io_bus.LdR        = r_ldr;
    assign io_bus.RD         = r_rd;
    assign io_bus.DataR      = r_data;
    assign io_bus.Busy       = r_busy;
    assign io_bus.OutCnt     = r_cnt;
endmodule

// File: tb/tb_reg_wb_scheduler.sv
// Bench for reg_wb_scheduler: directed scenarios plus randomized traffic against a
// cycle-level reference model of the scoreboard and write-port arbitration.
module tb_reg_wb_scheduler;
    localparam int unsigned MAX_OUT = 4;
    localparam int unsigned CNT_W   = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    reg_wb_scheduler_if #(.CNT_W(CNT_W)) bus ();

    reg_wb_scheduler #(
        .MAX_OUT(MAX_OUT),
        .CNT_W  (CNT_W)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .io_bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit          m_busy[32];
    int          m_cnt;
    bit          m_ptr_m;
    bit          m_ldr;
    int          m_rd;
    logic [31:0] m_data;
    int          cyc;
    int          ret_due[$];
    int          ret_rd[$];
    bit          e_ir, e_ga, e_gm;

    function automatic logic [31:0] busy_vec();
        logic [31:0] v = '0;
        for (int i = 0; i < 32; i++) v[i] = m_busy[i];
        return v;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        m_cnt = 0; m_ptr_m = 1'b0; m_ldr = 1'b0; m_rd = 0; m_data = '0;
        ret_due.delete(); ret_rd.delete();
    endfunction

    task automatic set_issue(input bit v, input int rs1, input int rs2, input bit u1,
                             input bit u2, input int rd, input bit we);
        bus.IssueValid = v; bus.IssueRS1 = 5'(rs1); bus.IssueRS2 = 5'(rs2);
        bus.IssueUseRS1 = u1; bus.IssueUseRS2 = u2; bus.IssueRD = 5'(rd); bus.IssueWrEn = we;
    endtask

    task automatic set_wb(input bit av, input int ard, input logic [31:0] ad,
                          input bit mv, input int mrd, input logic [31:0] md);
        bus.WbAValid = av; bus.WbARD = 5'(ard); bus.WbAData = ad;
        bus.WbMValid = mv; bus.WbMRD = 5'(mrd); bus.WbMData = md;
    endtask

    task automatic drive_idle();
        set_issue(0, 0, 0, 0, 0, 0, 0);
        set_wb(0, 0, '0, 0, 0, '0);
        bus.Flush = 1'b0;
    endtask

    // Let combinational outputs settle and compute what the model expects of them
    task automatic settle();
        bit real_wr;
        #1;
        real_wr = bus.IssueWrEn && (bus.IssueRD != 5'd0);
        e_ir = 1'b1;
        if (bus.IssueUseRS1 && m_busy[bus.IssueRS1]) e_ir = 1'b0;
        if (bus.IssueUseRS2 && m_busy[bus.IssueRS2]) e_ir = 1'b0;
        if (real_wr && m_busy[bus.IssueRD]) e_ir = 1'b0;
        if (real_wr && m_cnt == int'(MAX_OUT)) e_ir = 1'b0;
        if (bus.Flush) e_ir = 1'b0;
        e_ga = 1'b0; e_gm = 1'b0;
        if (bus.WbAValid && bus.WbMValid) begin
            if (m_ptr_m) e_gm = 1'b1; else e_ga = 1'b1;
        end else if (bus.WbAValid) begin
            e_ga = 1'b1;
        end else if (bus.WbMValid) begin
            e_gm = 1'b1;
        end
    endtask

    // Advance one clock and apply the same edge to the model
    task automatic tick();
        bit fire, ga, gm;
        int ird, grd;
        logic [31:0] gdat;
        fire = bus.IssueValid && e_ir && bus.IssueWrEn && (bus.IssueRD != 5'd0);
        ird  = int'(bus.IssueRD);
        ga = e_ga; gm = e_gm;
        grd  = ga ? int'(bus.WbARD) : int'(bus.WbMRD);
        gdat = ga ? bus.WbAData : bus.WbMData;
        @(posedge clk);
        while (ret_due.size() > 0 && ret_due[0] == cyc) begin
            m_busy[ret_rd[0]] = 1'b0;
            if (m_cnt > 0) m_cnt--;
            void'(ret_due.pop_front());
            void'(ret_rd.pop_front());
        end
        if (fire) begin
            m_busy[ird] = 1'b1;
            m_cnt++;
        end
        if (ga || gm) begin
            m_rd = grd; m_data = gdat; m_ldr = (grd != 0); m_ptr_m = ga;
            if (m_ldr) begin
                ret_due.push_back(cyc + 1);
                ret_rd.push_back(grd);
            end
        end else begin
            m_ldr = 1'b0;
        end
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        drive_idle();
        rst_n = 1'b0;
        #7;
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive_idle();
        rst_n = 1'b0;
        #12;
        checks++; if (bus.LdR !== 1'b0) begin errors++; $display("FAIL reset_ldr: got %0b want 0", bus.LdR); end
        checks++; if (bus.RD !== 5'd0) begin errors++; $display("FAIL reset_rd: got %0d want 0", bus.RD); end
        checks++; if (bus.DataR !== 32'd0) begin errors++; $display("FAIL reset_data: got %0h want 0", bus.DataR); end
        checks++; if (bus.Busy !== 32'd0) begin errors++; $display("FAIL reset_busy: got %0h want 0", bus.Busy); end
        checks++; if (bus.OutCnt !== 4'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", bus.OutCnt); end
        do_reset();
        set_issue(1, 1, 2, 1, 1, 5, 1);
        set_wb(1, 3, 32'h1, 1, 4, 32'h2);
        #1;
        checks++; if (bus.IssueReady !== 1'b1) begin errors++; $display("FAIL reset_issue_ready: got %0b want 1", bus.IssueReady); end
        checks++; if (bus.WbAReady !== 1'b1 || bus.WbMReady !== 1'b0) begin
            errors++; $display("FAIL reset_ptr_a: got A=%0b M=%0b want A=1 M=0", bus.WbAReady, bus.WbMReady);
        end
        drive_idle();
        settle();
        tick();
    endtask

    task automatic test_raw();
        set_issue(1, 1, 2, 1, 1, 5, 1);
        settle();
        checks++; if (bus.IssueReady !== 1'b1) begin errors++; $display("FAIL add_x5_ready: got %0b want 1", bus.IssueReady); end
        tick();
        checks++; if (bus.Busy[5] !== 1'b1 || bus.OutCnt !== 4'd1) begin
            errors++; $display("FAIL add_x5_busy: got busy5=%0b cnt=%0d want 1/1", bus.Busy[5], bus.OutCnt);
        end
        set_issue(1, 5, 0, 1, 0, 7, 1);
        set_wb(1, 5, 32'hDEADBEEF, 0, 0, '0);
        settle();
        checks++; if (bus.IssueReady !== 1'b0) begin errors++; $display("FAIL raw_stall: got %0b want 0", bus.IssueReady); end
        checks++; if (bus.WbAReady !== 1'b1) begin errors++; $display("FAIL raw_wb_grant: got %0b want 1", bus.WbAReady); end
        tick();
        set_wb(0, 0, '0, 0, 0, '0);
        checks++; if (bus.LdR !== 1'b1 || bus.RD !== 5'd5 || bus.DataR !== 32'hDEADBEEF) begin
            errors++; $display("FAIL raw_wport: got ldr=%0b rd=%0d data=%0h want 1/5/deadbeef", bus.LdR, bus.RD, bus.DataR);
        end
        settle();
        checks++; if (bus.IssueReady !== 1'b0) begin errors++; $display("FAIL raw_t1_stall: got %0b want 0", bus.IssueReady); end
        tick();
        checks++; if (bus.Busy[5] !== 1'b0 || bus.OutCnt !== 4'd0) begin
            errors++; $display("FAIL raw_retire: got busy5=%0b cnt=%0d want 0/0", bus.Busy[5], bus.OutCnt);
        end
        settle();
        checks++; if (bus.IssueReady !== 1'b1) begin errors++; $display("FAIL raw_t2_ready: got %0b want 1", bus.IssueReady); end
        drive_idle();
        settle();
        tick();
    endtask

    task automatic test_arb_alternate();
        bit prev_a;
        set_wb(0, 0, '0, 1, 4, 32'h44);  // one lone M grant puts the pointer on A
        settle();
        tick();
        prev_a = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_wb(1, 3, 32'hA0 + i, 1, 4, 32'hB0 + i);
            settle();
            checks++; if (bus.WbAReady !== e_ga || bus.WbMReady !== e_gm || bus.WbAReady === prev_a) begin
                errors++; $display("FAIL arb_alt%0d: got A=%0b M=%0b want A=%0b M=%0b", i, bus.WbAReady, bus.WbMReady, e_ga, e_gm);
            end
            prev_a = e_ga;
            tick();
            checks++; if (bus.LdR !== 1'b1 || bus.RD !== 5'(m_rd) || bus.DataR !== m_data) begin
                errors++; $display("FAIL arb_wport%0d: got ldr=%0b rd=%0d data=%0h want 1/%0d/%0h", i, bus.LdR, bus.RD, bus.DataR, m_rd, m_data);
            end
        end
        drive_idle();
        settle();
        tick();
    endtask

    task automatic test_rd0();
        set_wb(1, 0, 32'h1234, 0, 0, '0);
        settle();
        checks++; if (bus.WbAReady !== 1'b1) begin errors++; $display("FAIL rd0_grant: got %0b want 1", bus.WbAReady); end
        tick();
        drive_idle();
        checks++; if (bus.LdR !== 1'b0 || bus.DataR !== 32'h1234) begin
            errors++; $display("FAIL rd0_ldr: got ldr=%0b data=%0h want 0/1234", bus.LdR, bus.DataR);
        end
        settle();
        tick();
        checks++; if (bus.Busy !== busy_vec() || bus.OutCnt !== CNT_W'(m_cnt)) begin
            errors++; $display("FAIL rd0_state: got busy=%0h cnt=%0d want %0h/%0d", bus.Busy, bus.OutCnt, busy_vec(), m_cnt);
        end
    endtask

    task automatic test_outstanding();
        for (int r = 6; r <= 9; r++) begin
            set_issue(1, 0, 0, 0, 0, r, 1);
            settle();
            checks++; if (bus.IssueReady !== 1'b1) begin errors++; $display("FAIL max_issue_x%0d: got %0b want 1", r, bus.IssueReady); end
            tick();
        end
        set_issue(1, 0, 0, 0, 0, 10, 1);
        settle();
        checks++; if (bus.IssueReady !== 1'b0 || bus.OutCnt !== 4'd4) begin
            errors++; $display("FAIL max_stall: got ready=%0b cnt=%0d want 0/4", bus.IssueReady, bus.OutCnt);
        end
        set_issue(1, 1, 2, 1, 1, 10, 0);
        settle();
        checks++; if (bus.IssueReady !== 1'b1) begin errors++; $display("FAIL max_nowrite_issue: got %0b want 1", bus.IssueReady); end
        tick();
        set_issue(1, 0, 0, 0, 0, 10, 1);
        set_wb(1, 6, 32'h66, 0, 0, '0);
        settle();
        checks++; if (bus.IssueReady !== 1'b0 || bus.WbAReady !== 1'b1) begin
            errors++; $display("FAIL max_t0: got ready=%0b grantA=%0b want 0/1", bus.IssueReady, bus.WbAReady);
        end
        tick();
        set_wb(0, 0, '0, 0, 0, '0);
        settle();
        checks++; if (bus.IssueReady !== 1'b0) begin errors++; $display("FAIL max_t1: got %0b want 0", bus.IssueReady); end
        tick();
        settle();
        checks++; if (bus.IssueReady !== 1'b1) begin errors++; $display("FAIL max_t2: got %0b want 1", bus.IssueReady); end
        tick();
        checks++; if (bus.Busy[10] !== 1'b1 || bus.OutCnt !== 4'd4) begin
            errors++; $display("FAIL max_fifth: got busy10=%0b cnt=%0d want 1/4", bus.Busy[10], bus.OutCnt);
        end
        drive_idle();
        for (int r = 7; r <= 10; r++) begin
            set_wb(0, 0, '0, 1, r, 32'(r));
            settle();
            tick();
        end
        drive_idle();
        settle(); tick();
        settle(); tick();
        checks++; if (bus.OutCnt !== 4'd0 || bus.Busy !== 32'd0) begin
            errors++; $display("FAIL max_drain: got cnt=%0d busy=%0h want 0/0", bus.OutCnt, bus.Busy);
        end
    endtask

    function automatic int pick_rd();
        int q[$];
        if ($urandom_range(0, 3) != 0) begin
            for (int i = 1; i < 32; i++) if (m_busy[i]) q.push_back(i);
            if (q.size() > 0) return q[$urandom_range(0, q.size() - 1)];
        end
        return int'($urandom_range(0, 31));
    endfunction

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            set_issue($urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 15),
                      $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 15),
                      $urandom_range(0, 3) != 0);
            bus.Flush = ($urandom_range(0, 7) == 0);
            set_wb($urandom_range(0, 2) == 0, pick_rd(), $urandom,
                   $urandom_range(0, 2) == 0, pick_rd(), $urandom);
            settle();
            checks++; if (bus.IssueReady !== e_ir) begin errors++; $display("FAIL rnd_ready@%0d: got %0b want %0b", i, bus.IssueReady, e_ir); end
            checks++; if (bus.WbAReady !== e_ga || bus.WbMReady !== e_gm) begin
                errors++; $display("FAIL rnd_grant@%0d: got A=%0b M=%0b want A=%0b M=%0b", i, bus.WbAReady, bus.WbMReady, e_ga, e_gm);
            end
            tick();
            checks++; if (bus.LdR !== m_ldr || bus.RD !== 5'(m_rd) || bus.DataR !== m_data) begin
                errors++; $display("FAIL rnd_wport@%0d: got %0b/%0d/%0h want %0b/%0d/%0h", i, bus.LdR, bus.RD, bus.DataR, m_ldr, m_rd, m_data);
            end
            checks++; if (bus.Busy !== busy_vec() || bus.OutCnt !== CNT_W'(m_cnt)) begin
                errors++; $display("FAIL rnd_sb@%0d: got busy=%0h cnt=%0d want %0h/%0d", i, bus.Busy, bus.OutCnt, busy_vec(), m_cnt);
            end
        end
        drive_idle();
        settle();
        tick();
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int r = 11; r <= 14; r++) begin
            set_issue(1, 0, 0, 0, 0, r, 1);
            settle();
            tick();
        end
        drive_idle();
        set_wb(1, 11, 32'hB, 0, 0, '0);
        settle(); tick();
        set_wb(1, 12, 32'hC, 0, 0, '0);
        settle(); tick();
        drive_idle();
        checks++; if (bus.LdR !== 1'b1 || bus.OutCnt !== 4'd3) begin
            errors++; $display("FAIL arst_pre: got ldr=%0b cnt=%0d want 1/3", bus.LdR, bus.OutCnt);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.LdR !== 1'b0 || bus.Busy !== 32'd0 || bus.OutCnt !== 4'd0) begin
            errors++; $display("FAIL arst_clear: got ldr=%0b busy=%0h cnt=%0d want 0/0/0", bus.LdR, bus.Busy, bus.OutCnt);
        end
        do_reset();
    endtask

    initial begin
        cyc = 0;
        model_clear();
        drive_idle();
        rst_n = 1'b0;
        test_reset();
        test_raw();
        test_arb_alternate();
        test_rd0();
        test_outstanding();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/reg_wb_scheduler.md
Name: reg_wb_scheduler

Overview:
Issue-side scoreboard and write-port arbiter for the 32x32 register file. It blocks instruction issue on RAW, WAW and outstanding-limit hazards. It shares the single register-file write port (LdR/RD/DataR) between two writeback requesters, ALU (A) and load unit (M), using round-robin arbitration. It sits between decode/issue and the register file, and drives the register file's write inputs from registers clocked on the rising edge.

Parameters:
MAX_OUT, 4, maximum number of issued, register-writing instructions not yet written back (1..15).
CNT_W, 4, width of the outstanding counter; must hold MAX_OUT.

Ports:
CLK  in  1  clock; all state updates on posedge.
RST_N  in  1  asynchronous, active-low reset.
IssueValid  in  1  decode presents an instruction.
IssueRS1  in  5  source register 1.
IssueRS2  in  5  source register 2.
IssueUseRS1  in  1  instruction reads RS1.
IssueUseRS2  in  1  instruction reads RS2.
IssueRD  in  5  destination register.
IssueWrEn  in  1  instruction writes RD.
IssueReady  out  1  combinational; issue accepted when IssueValid && IssueReady.
Flush  in  1  pipeline flush.
WbAValid  in  1  ALU writeback request.
WbARD  in  5  ALU destination.
WbAData  in  32  ALU result.
WbAReady  out  1  combinational grant to A.
WbMValid  in  1  load writeback request.
WbMRD  in  5  load destination.
WbMData  in  32  load result.
WbMReady  out  1  combinational grant to M.
LdR  out  1  register-file write enable (registered).
RD  out  5  register-file write address (registered).
DataR  out  32  register-file write data (registered).
Busy  out  32  scoreboard bits; bit 0 is always 0.
OutCnt  out  CNT_W  number of outstanding writes.

Behaviour:
- Reset (async, RST_N low): LdR=0, RD=0, DataR=0, Busy=0, OutCnt=0, round-robin pointer = A. Combinational ready outputs follow from this state.
- Effective RD: a write is "real" only when WrEn=1 and RD!=0. Writes to RD=0 never set Busy and never count toward OutCnt.
- IssueReady = !(UseRS1 && Busy[RS1]) && !(UseRS2 && Busy[RS2]) && !(real write && Busy[RD]) && !(real write && OutCnt==MAX_OUT) && !Flush.
  - The OutCnt==MAX_OUT condition applies only to real-write instructions; others issue freely.
- Issue accept of a real write: on the next posedge, Busy[RD] is set and OutCnt increments.
- Arbitration (combinational):
  - Only one requester valid: that requester is granted.
  - Both valid: the pointer side is granted.
  - After any grant, the pointer moves to the non-granted side.
  - At most one Ready is high per cycle.
- Granted writeback at cycle t:
  - At posedge ending t: RD<=rd, DataR<=data, LdR<=(rd!=0).
  - LdR must be 0 for rd=0, because the register file would otherwise overwrite R0.
  - The register file commits the value on the negedge within t+1.
  - At posedge ending t+1: Busy[rd] clears and OutCnt decrements (if rd!=0).
  - A dependent instruction can therefore first issue in t+2, and its negedge read sees the new value.
- No grant in a cycle: LdR<=0 on the next posedge; RD and DataR hold their values.
- Same-posedge Busy set (issue) and clear (writeback retire) on the same register cannot occur due to the WAW check. For robustness, set wins.
- Same-posedge OutCnt increment and decrement: the count is unchanged.
- OutCnt never exceeds MAX_OUT and never underflows. A retire at OutCnt==0 is a protocol error and is ignored (saturates at 0).
- Flush:
  - Forces IssueReady=0 that cycle.
  - Does not clear Busy or OutCnt; in-flight writebacks still arrive and retire normally.
  - Arbitration and the write port are unaffected.
- Reset mid-operation: all state clears immediately; LdR drops asynchronously.

Test Plan:
- Reset, then issue ADD x5 (WrEn=1, RS1=x1, RS2=x2) -> IssueReady=1; next cycle Busy[5]=1, OutCnt=1.
- With Busy[5]=1, present an instruction with RS1=x5 -> IssueReady=0. WbA grants x5=0xDEADBEEF at t -> LdR=1, RD=5, DataR=0xDEADBEEF at t+1; Busy[5]=0 at t+2; IssueReady=1 in t+2.
- WbAValid and WbMValid both high for 4 cycles, A(rd=3), M(rd=4) -> grants alternate A, M, A, M; LdR high every cycle.
- Writeback with rd=0, data=0x1234 -> WbAReady=1, LdR stays 0, Busy and OutCnt unchanged.
- Issue MAX_OUT=4 real writes to x6..x9, then a fifth to x10 -> fifth stalls. Retire x6 -> fifth issues two cycles after the grant. An instruction with WrEn=0 issues during the stall.
- Assert RST_N low while OutCnt=3 and LdR=1 -> LdR, Busy and OutCnt drop to 0 without a clock edge.
